// File: rtl/merge13_leaf_if.sv
// Channel bundle for the merge13 leaf: two input packet channels, one output
// packet channel and the 1-bit select side channel.
interface merge13_leaf_if #(
  parameter int unsigned W = 9
);
  logic         in0_valid;
  logic [W-1:0] in0_data;
  logic         in0_ready;
  logic         in1_valid;
  logic [W-1:0] in1_data;
  logic         in1_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         s_valid;
  logic         s_data;
  logic         s_ready;

  // Merge leaf side
  modport slave (
    input  in0_valid, in0_data, in1_valid, in1_data, out_ready, s_ready,
    output in0_ready, in1_ready, out_valid, out_data, s_valid, s_data
  );

  // Environment side (upstream producers and downstream consumers)
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, out_ready, s_ready,
    input  in0_ready, in1_ready, out_valid, out_data, s_valid, s_data
  );
endinterface

// File: rtl/merge13_leaf.sv
// 2:1 packet merge leaf. Arbitrates In0/In1 onto Out, locking on the winning
// input from head to tail, and publishes the winner index once per packet on S.
module merge13_leaf #(
  parameter int unsigned W        = 9,
  parameter int unsigned TAIL_BIT = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  merge13_leaf_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e       state_q, state_d;
  logic         prio_q, prio_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         s_valid_q, s_valid_d;
  logic         s_data_q, s_data_d;

  logic         out_load_ok, s_load_ok;
  logic         gnt_idx;
  logic         in0_ready_c, in1_ready_c;
  logic         xfer0, xfer1, xfer, head;
  logic [W-1:0] xfer_data;

  // Ready generation and accepted-flit selection
  always_comb begin
    out_load_ok = !out_valid_q || bus.out_ready;
    s_load_ok   = !s_valid_q || bus.s_ready;
    // Contention goes to prio; otherwise whichever input is valid.
    gnt_idx     = (bus.in0_valid && bus.in1_valid) ? prio_q : bus.in1_valid;
    in0_ready_c = 1'b0;
    in1_ready_c = 1'b0;
    if (!RESET) begin
      case (state_q)
        IDLE: begin
          if (out_load_ok && s_load_ok && (bus.in0_valid || bus.in1_valid)) begin
            in0_ready_c = !gnt_idx;
            in1_ready_c = gnt_idx;
          end
        end
        LOCK0:   in0_ready_c = out_load_ok;
        LOCK1:   in1_ready_c = out_load_ok;
        default: ;
      endcase
    end
    xfer0     = in0_ready_c && bus.in0_valid;
    xfer1     = in1_ready_c && bus.in1_valid;
    xfer      = xfer0 || xfer1;
    head      = xfer && (state_q == IDLE);
    xfer_data = xfer1 ? bus.in1_data : bus.in0_data;
  end

  // Next-state: lock tracking, output register loads and drains
  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    s_valid_d   = s_valid_q && !bus.s_ready;
    s_data_d    = s_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = xfer_data;
      if (head) begin
        s_valid_d = 1'b1;
        s_data_d  = xfer1;
        prio_d    = !xfer1;
        if (!xfer_data[TAIL_BIT]) begin
          state_d = xfer1 ? LOCK1 : LOCK0;
        end
      end else if (xfer_data[TAIL_BIT]) begin
        state_d = IDLE;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      s_valid_q   <= 1'b0;
      s_data_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      s_valid_q   <= s_valid_d;
      s_data_q    <= s_data_d;
    end
  end

  assign bus.in0_ready = in0_ready_c;
  assign bus.in1_ready = in1_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.s_valid   = s_valid_q;
  assign bus.s_data    = s_data_q;

endmodule
